// File: rtl/butterfly_pipe.sv
// Radix-2 complex butterfly: X = A + W*B, Y = A - W*B.
// Three-stage pipeline (products, complex combine, add/sub) with a single
// global stall enable driven by output backpressure. Fixed-point data with
// FRAC fractional bits; every add/sub saturates and reports into a sticky flag.

module butterfly_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    input  logic signed [WIDTH-1:0] w_re,
    input  logic signed [WIDTH-1:0] w_im,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_re,
    output logic signed [WIDTH-1:0] x_im,
    output logic signed [WIDTH-1:0] y_re,
    output logic signed [WIDTH-1:0] y_im,

    output logic                    sat_flag,
    input  logic                    sat_clr,
    output logic [15:0]             bfly_count
);

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Sign-magnitude fixed-point multiply. The magnitude is formed from the
    // 15-bit magnitudes of both operands, shifted right by FRAC and wrapped
    // to 15 bits; the most negative code therefore has magnitude zero.
    // A zero magnitude always returns +0.
    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] op_x,
        input logic signed [WIDTH-1:0] op_y
    );
        logic [WIDTH-1:0]   neg_x;
        logic [WIDTH-1:0]   neg_y;
        logic [WIDTH-2:0]   mag_x;
        logic [WIDTH-2:0]   mag_y;
        logic [2*WIDTH-3:0] prod;
        logic [WIDTH-2:0]   mag;
        logic [WIDTH-1:0]   ext;
        logic               sgn;
        neg_x = -op_x;
        neg_y = -op_y;
        mag_x = op_x[WIDTH-1] ? neg_x[WIDTH-2:0] : op_x[WIDTH-2:0];
        mag_y = op_y[WIDTH-1] ? neg_y[WIDTH-2:0] : op_y[WIDTH-2:0];
        prod  = {{(WIDTH-1){1'b0}}, mag_x} * {{(WIDTH-1){1'b0}}, mag_y};
        mag   = prod[FRAC +: (WIDTH-1)];
        sgn   = op_x[WIDTH-1] ^ op_y[WIDTH-1];
        ext   = {1'b0, mag};
        if (mag == '0) begin
            return '0;
        end else if (sgn) begin
            return $signed(~ext + 1'b1);
        end else begin
            return $signed(ext);
        end
    endfunction

    // True when a WIDTH+1 bit result does not fit in WIDTH bits.
    function automatic logic is_ovf(input logic signed [WIDTH:0] v);
        return v[WIDTH] ^ v[WIDTH-1];
    endfunction

    // Clamp a WIDTH+1 bit result to the WIDTH-bit signed range.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
        if (is_ovf(v)) begin
            return v[WIDTH] ? $signed({1'b1, {(WIDTH-1){1'b0}}})
                            : $signed({1'b0, {(WIDTH-1){1'b1}}});
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    // Sign-extending add / subtract into WIDTH+1 bits.
    function automatic logic signed [WIDTH:0] add_w(
        input logic signed [WIDTH-1:0] p,
        input logic signed [WIDTH-1:0] q
    );
        return {p[WIDTH-1], p} + {q[WIDTH-1], q};
    endfunction

    function automatic logic signed [WIDTH:0] sub_w(
        input logic signed [WIDTH-1:0] p,
        input logic signed [WIDTH-1:0] q
    );
        return {p[WIDTH-1], p} - {q[WIDTH-1], q};
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                    w_en;

    logic                    r_vld_p1;
    logic signed [WIDTH-1:0] r_prr_p1;
    logic signed [WIDTH-1:0] r_pii_p1;
    logic signed [WIDTH-1:0] r_pri_p1;
    logic signed [WIDTH-1:0] r_pir_p1;
    logic signed [WIDTH-1:0] r_are_p1;
    logic signed [WIDTH-1:0] r_aim_p1;

    logic                    r_vld_p2;
    logic signed [WIDTH-1:0] r_tre_p2;
    logic signed [WIDTH-1:0] r_tim_p2;
    logic signed [WIDTH-1:0] r_are_p2;
    logic signed [WIDTH-1:0] r_aim_p2;

    logic                    r_vld_p3;
    logic signed [WIDTH-1:0] r_xre_p3;
    logic signed [WIDTH-1:0] r_xim_p3;
    logic signed [WIDTH-1:0] r_yre_p3;
    logic signed [WIDTH-1:0] r_yim_p3;

    logic                    r_sat_flag;
    logic [15:0]             r_count;

    logic signed [WIDTH:0]   w_tre_wide;
    logic signed [WIDTH:0]   w_tim_wide;
    logic signed [WIDTH:0]   w_xre_wide;
    logic signed [WIDTH:0]   w_xim_wide;
    logic signed [WIDTH:0]   w_yre_wide;
    logic signed [WIDTH:0]   w_yim_wide;
    logic                    w_sat_s2;
    logic                    w_sat_s3;
    logic                    w_sat_set;
    logic                    w_out_xfer;

    // The whole pipe moves together; it only stalls when a result is
    // waiting at the output and downstream is not taking it.
    assign w_en       = !r_vld_p3 || out_ready;
    assign in_ready   = w_en;
    assign w_out_xfer = r_vld_p3 && out_ready;

    // Stage 2 / stage 3 wide arithmetic and overflow detection.
    assign w_tre_wide = sub_w(r_prr_p1, r_pii_p1);
    assign w_tim_wide = add_w(r_pri_p1, r_pir_p1);
    assign w_xre_wide = add_w(r_are_p2, r_tre_p2);
    assign w_xim_wide = add_w(r_aim_p2, r_tim_p2);
    assign w_yre_wide = sub_w(r_are_p2, r_tre_p2);
    assign w_yim_wide = sub_w(r_aim_p2, r_tim_p2);

    // Saturation only counts for real data that actually moves forward.
    assign w_sat_s2  = r_vld_p1 && (is_ovf(w_tre_wide) || is_ovf(w_tim_wide));
    assign w_sat_s3  = r_vld_p2 && (is_ovf(w_xre_wide) || is_ovf(w_xim_wide) ||
                                    is_ovf(w_yre_wide) || is_ovf(w_yim_wide));
    assign w_sat_set = w_en && (w_sat_s2 || w_sat_s3);

    // ---- stage boundary: S1 (twiddle products) ----
    // Stage-1 data: four partial products and A delayed alongside.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_prr_p1 <= fx_mul(b_re, w_re);
            r_pii_p1 <= fx_mul(b_im, w_im);
            r_pri_p1 <= fx_mul(b_re, w_im);
            r_pir_p1 <= fx_mul(b_im, w_re);
            r_are_p1 <= a_re;
            r_aim_p1 <= a_im;
        end
    end

    // ---- stage boundary: S2 (complex combine, t = W*B) ----
    // Stage-2 data: saturated real/imag parts of W*B plus delayed A.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_tre_p2 <= sat(w_tre_wide);
            r_tim_p2 <= sat(w_tim_wide);
            r_are_p2 <= r_are_p1;
            r_aim_p2 <= r_aim_p1;
        end
    end

    // ---- stage boundary: S3 (butterfly add/sub, registered outputs) ----
    // Output data registers; cleared by reset so nothing stale is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xre_p3 <= '0;
            r_xim_p3 <= '0;
            r_yre_p3 <= '0;
            r_yim_p3 <= '0;
        end else if (w_en) begin
            r_xre_p3 <= sat(w_xre_wide);
            r_xim_p3 <= sat(w_xim_wide);
            r_yre_p3 <= sat(w_yre_wide);
            r_yim_p3 <= sat(w_yim_wide);
        end
    end

    // Valid bits travel with the data; bubbles are carried, not collapsed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
        end else if (w_sat_set) begin
            r_sat_flag <= 1'b1;
        end else if (sat_clr) begin
            r_sat_flag <= 1'b0;
        end
    end

    // Count of results handed downstream, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_valid  = r_vld_p3;
    assign x_re       = r_xre_p3;
    assign x_im       = r_xim_p3;
    assign y_re       = r_yre_p3;
    assign y_im       = r_yim_p3;
    assign sat_flag   = r_sat_flag;
    assign bfly_count = r_count;

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter: WIDTH, 16, data word width; two's complement, 6 fractional bits (1.0 = 0x0040).
REQ-002 Parameter: FRAC, 6, number of fractional bits dropped after each product.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  the input operand set is valid.
REQ-006 in_ready  output  1  the block accepts the input set this cycle.
REQ-007 a_re, a_im, b_re, b_im  input  16 each  butterfly inputs A and B.
REQ-008 w_re, w_im  input  16 each  twiddle factor W.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 x_re, x_im, y_re, y_im  output  16 each  X = A + W*B and Y = A - W*B.
REQ-012 sat_flag  output  1  sticky flag; any add or subtract saturated since the last clear.
REQ-013 sat_clr  input  1  clears sat_flag.
REQ-014 bfly_count  output  16  number of results handed off; wraps at 0xFFFF to 0x0000.

Function
REQ-015 An input transfer occurs on in_valid && in_ready; an output transfer occurs on out_valid && out_ready.
REQ-016 Pipeline enable en = !out_valid || out_ready; in_ready = en; all stages advance only when en = 1.
REQ-017 The pipeline has 3 stages (S1 products, S2 complex combine, S3 add/sub), each with its own valid bit; latency is 3 cycles with en held high, and throughput is 1 result per cycle.
REQ-018 Bubbles are not collapsed; an empty stage advances as an invalid slot.
REQ-019 While out_valid && !out_ready, all outputs and all stage contents are held stable.
REQ-020 S1 computes p_rr = b_re*w_re, p_ii = b_im*w_im, p_ri = b_re*w_im, p_ir = b_im*w_re; operand A is delayed alongside.
REQ-021 Product rule: magnitude = ((|x| * |y|) >> FRAC) mod 2^15, using the 15-bit magnitude of each operand.
REQ-022 Product rule: sign = sign(x) XOR sign(y); result = +magnitude or -magnitude in two's complement.
REQ-023 Product rule: a zero magnitude yields 0x0000, never negative zero; an operand of 0x8000 has magnitude 0, so the product is 0.
REQ-024 S2 computes t_re = p_rr - p_ii and t_im = p_ri + p_ir in 17 bits, then saturates to 16 bits.
REQ-025 S3 computes x = a + t and y = a - t per component in 17 bits, then saturates to 16 bits.
REQ-026 Saturation clamps to 0x7FFF (positive overflow) or 0x8000 (negative overflow).
REQ-027 sat_flag sets on any saturation in S2 or S3 of a valid slot that advances (en = 1); saturation in an invalid slot is ignored.
REQ-028 If sat_clr and a new saturation occur in the same cycle, sat_flag = 1 (set wins).
REQ-029 bfly_count increments by 1 on each output transfer.
REQ-030 Output data are registered and are meaningful only while out_valid = 1.

Reset
REQ-031 While rst_n = 0 at a clock edge: all stage valid bits = 0, out_valid = 0, x/y outputs = 0x0000, sat_flag = 0, bfly_count = 0.
REQ-032 During reset, in_ready = 1 (because out_valid = 0).
REQ-033 Reset mid-operation discards all in-flight data; no result from before reset ever appears afterward.

Verification
REQ-034 Identity: a=(0x0040,0), b=(0x0040,0), w=(0x0040,0) -> 3 cycles later x=(0x0080,0), y=(0,0); bfly_count=1.
REQ-035 Twiddle j: a=(0,0), b=(0x0040,0), w=(0,0x0040) -> x=(0,0x0040), y=(0,0xFFC0); a zero product has sign bit 0.
REQ-036 Negative and special operands: b=(0xFFC0,0), w=(0x0040,0), a=0 -> x=(0xFFC0,0), y=(0x0040,0); b_re=0x8000 -> t=0, so x=y=a.
REQ-037 Saturation: a=(0x7F00,0), b=(0x0400,0), w=(0x0040,0) -> x_re=0x7FFF, y_re=0x7B00, sat_flag=1; sat_clr=1 one cycle later -> sat_flag=0.
REQ-038 Backpressure: stream 5 sets with out_ready=0 for 6 cycles -> in_ready=0 once out_valid=1, outputs stable, then all 5 results in order and none lost; bfly_count=5.
REQ-039 Reset mid-stream: rst_n=0 for 1 cycle with 3 sets in flight -> out_valid=0, sat_flag=0, bfly_count=0 next cycle; no stale result appears afterward.
